seven_seg_scan_decoder: RTL and testbench

//  Receive-side counterpart of the hex-to-seven-segment encoder. Samples a multiplexed,

---
 rtl/seven_seg_scan_decoder.sv | 220 ++++++++++++++++++++++
 tb/tb_seven_seg_scan_decoder.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_decoder.sv
// Seven-segment scan decoder: samples a multiplexed active-low segment/anode
// bus, waits for a stable pattern, decodes the glyph and stores it per digit.
module seven_seg_scan_decoder #(
  parameter int N_DIGITS      = 8,
  parameter int STABLE_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [7:0]            seg_in,
  input  logic [N_DIGITS-1:0]   an_in,
  output logic [4*N_DIGITS-1:0] digits_out,
  output logic [N_DIGITS-1:0]   dp_out,
  output logic [N_DIGITS-1:0]   digit_valid,
  output logic                  capture,
  output logic [2:0]            capt_idx,
  output logic                  err
);
  localparam int         SMP_W    = 8 + N_DIGITS;
  localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, TRACK, CAPT, HOLD} state_t;

  // {hit, nibble} for a segment pattern {a..g}, 0 = segment on
  function automatic logic [4:0] glyph_dec(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'b0000001: r = 5'h10;
      7'b1001111: r = 5'h11;
      7'b0010010: r = 5'h12;
      7'b0000110: r = 5'h13;
      7'b1001100: r = 5'h14;
      7'b0100100: r = 5'h15;
      7'b0100000: r = 5'h16;
      7'b0001111: r = 5'h17;
      7'b0000000: r = 5'h18;
      7'b0000100: r = 5'h19;
      7'b0001000: r = 5'h1A;
      7'b1100000: r = 5'h1B;
      7'b0110001: r = 5'h1C;
      7'b1000010: r = 5'h1D;
      7'b0110000: r = 5'h1E;
      7'b0111000: r = 5'h1F;
      default:    r = 5'h00;
    endcase
    return r;
  endfunction

  // exactly one anode driven low
  function automatic logic an_legal(input logic [N_DIGITS-1:0] a);
    int zeros;
    zeros = 0;
    for (int i = 0; i < N_DIGITS; i++) if (!a[i]) zeros++;
    return zeros == 1;
  endfunction

  // position of the low anode (meaningful only when an_legal)
  function automatic logic [2:0] an_pos(input logic [N_DIGITS-1:0] a);
    logic [2:0] p;
    p = '0;
    for (int i = 0; i < N_DIGITS; i++) if (!a[i]) p = 3'(i);
    return p;
  endfunction

  // ---------------------------------------------------------------- reset
  logic [1:0] rst_sync_q, rst_sync_d;
  logic       rst_n;

  // reset release ripples through two flops before reaching the core
  always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

  // reset synchronizer: asynchronous assert, synchronous release
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) rst_sync_q <= '0;
    else          rst_sync_q <= rst_sync_d;

  assign rst_n = rst_sync_q[1];

  // ---------------------------------------------------------------- input sync
  logic [SMP_W-1:0] sync1_q, sync1_d, smp_q, smp_d;

  // two-stage synchronizer on the whole {seg, an} bus
  always_comb begin
    sync1_d = {seg_in, an_in};
    smp_d   = sync1_q;
  end

  // synchronizer flops
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync1_q <= '0;
      smp_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      smp_q   <= smp_d;
    end

  logic smp_ok;
  assign smp_ok = an_legal(smp_q[N_DIGITS-1:0]);

  // ---------------------------------------------------------------- core
  state_t                state_q, state_d;
  logic [SMP_W-1:0]      pat_q, pat_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [4*N_DIGITS-1:0] digits_q, digits_d;
  logic [N_DIGITS-1:0]   dp_q, dp_d, valid_q, valid_d;
  logic                  capture_q, capture_d, err_q, err_d;
  logic [2:0]            idx_q, idx_d;

  logic [7:0] pat_seg;
  logic [2:0] pat_k;
  logic [4:0] pat_dec;
  assign pat_seg = pat_q[SMP_W-1 -: 8];
  assign pat_k   = an_pos(pat_q[N_DIGITS-1:0]);
  assign pat_dec = glyph_dec(pat_seg[7:1]);

  // stability tracking FSM and per-digit capture update
  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    cnt_d     = cnt_q;
    digits_d  = digits_q;
    dp_d      = dp_q;
    valid_d   = valid_q;
    idx_d     = idx_q;
    capture_d = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (smp_ok) begin
          state_d = TRACK;
          pat_d   = smp_q;
          cnt_d   = 8'd1;
        end
      end
      TRACK: begin
        if (!smp_ok) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (smp_q != pat_q) begin
          // seg and an changing together still count as a single restart
          pat_d = smp_q;
          cnt_d = 8'd1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = CAPT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      CAPT: begin
        state_d = HOLD;
        cnt_d   = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
          if (3'(i) == pat_k) begin
            if (pat_dec[4]) begin
              digits_d[4*i +: 4] = pat_dec[3:0];
              dp_d[i]            = ~pat_seg[0];
              valid_d[i]         = 1'b1;
              capture_d          = 1'b1;
              idx_d              = pat_k;
            end else if (pat_seg[7:1] == 7'h7F) begin
              // blank digit: keeps old nibble, DP still tracked
              valid_d[i] = 1'b0;
              dp_d[i]    = ~pat_seg[0];
            end else begin
              valid_d[i] = 1'b0;
              err_d      = 1'b1;
              idx_d      = pat_k;
            end
          end
        end
      end
      HOLD: begin
        // no recapture until the bus moves
        if (smp_q != pat_q) begin
          if (smp_ok) begin
            state_d = TRACK;
            pat_d   = smp_q;
            cnt_d   = 8'd1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // core state and output registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q   <= IDLE;
      pat_q     <= '0;
      cnt_q     <= '0;
      digits_q  <= '0;
      dp_q      <= '0;
      valid_q   <= '0;
      capture_q <= 1'b0;
      err_q     <= 1'b0;
      idx_q     <= '0;
    end else begin
      state_q   <= state_d;
      pat_q     <= pat_d;
      cnt_q     <= cnt_d;
      digits_q  <= digits_d;
      dp_q      <= dp_d;
      valid_q   <= valid_d;
      capture_q <= capture_d;
      err_q     <= err_d;
      idx_q     <= idx_d;
    end

  assign digits_out  = digits_q;
  assign dp_out      = dp_q;
  assign digit_valid = valid_q;
  assign capture     = capture_q;
  assign err         = err_q;
  assign capt_idx    = idx_q;

endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// Directed bench for seven_seg_scan_decoder (N_DIGITS=8, STABLE_CYCLES=16).
module tb_seven_seg_scan_decoder;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  seg_in;
  logic [7:0]  an_in;
  logic [31:0] digits_out;
  logic [7:0]  dp_out;
  logic [7:0]  digit_valid;
  logic        capture;
  logic [2:0]  capt_idx;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;

  // segment patterns {a..g}, 0 = on, for values 0..F
  logic [6:0] glyph [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  seven_seg_scan_decoder #(.N_DIGITS(8), .STABLE_CYCLES(16)) dut (
    .clk(clk), .reset_n(reset_n), .seg_in(seg_in), .an_in(an_in),
    .digits_out(digits_out), .dp_out(dp_out), .digit_valid(digit_valid),
    .capture(capture), .capt_idx(capt_idx), .err(err));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  // run n cycles, sampling 1ns after each edge; cyc = edge index of first pulse
  task automatic watch(input int n, output int ncap, output int nerr, output int cyc);
    ncap = 0; nerr = 0; cyc = -1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if ((capture || err) && cyc < 0) cyc = i;
      if (capture) ncap++;
      if (err) nerr++;
    end
  endtask

  int nc, ne, cy, err_tot;

  initial begin
    reset_n = 1'b0; seg_in = 8'hFF; an_in = 8'hFF;
    repeat (3) @(posedge clk); #1;
    chk("rst_digits", digits_out, 32'h0);
    chk("rst_dp", {24'h0, dp_out}, 32'h0);
    chk("rst_valid", {24'h0, digit_valid}, 32'h0);
    chk("rst_pulses", {30'h0, capture, err}, 32'h0);
    reset_n = 1'b1;
    watch(6, nc, ne, cy);
    chk("idle_pulses", nc + ne, 0);

    // T2: "3" on digit 2, DP off
    an_in = 8'hFB; seg_in = 8'h0D;
    watch(20, nc, ne, cy);
    chk("t2_ncap", nc, 1);
    chk("t2_cyc", cy, 18);
    chk("t2_nerr", ne, 0);
    chk("t2_idx", {29'h0, capt_idx}, 2);
    chk("t2_digits", digits_out, 32'h0000_0300);
    chk("t2_dp", {24'h0, dp_out}, 32'h0);
    chk("t2_valid", {24'h0, digit_valid}, 32'h04);

    // T3: scan every digit through 0..F, DP lit on odd digits
    err_tot = 0;
    for (int d = 0; d < 8; d++) begin
      for (int v = 0; v < 16; v++) begin
        an_in  = ~(8'd1 << d);
        seg_in = {glyph[v], ~d[0]};
        watch(32, nc, ne, cy);
        err_tot += ne;
        chk("t3_ncap", nc, 1);
        chk("t3_cyc", cy, 18);
        chk("t3_idx", {29'h0, capt_idx}, d);
        chk("t3_nib", {28'h0, digits_out[4*d +: 4]}, v);
      end
    end
    chk("t3_err", err_tot, 0);
    chk("t3_dp", {24'h0, dp_out}, 32'hAA);
    chk("t3_valid", {24'h0, digit_valid}, 32'hFF);
    chk("t3_digits", digits_out, 32'hFFFF_FFFF);

    // T4: one-cycle glitch on segment bit 4 moves the capture 10 cycles later
    an_in = 8'hFE; seg_in = {glyph[5], 1'b1};
    nc = 0; cy = -1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (capture) begin nc++; if (cy < 0) cy = i; end
      if (i == 8 || i == 9) seg_in[4] = ~seg_in[4];
    end
    chk("t4_ncap", nc, 1);
    chk("t4_cyc", cy, 28);
    chk("t4_digits", digits_out, 32'hFFFF_FFF5);
    // short dwell then anodes off: nothing captured
    an_in = 8'hFD; seg_in = {glyph[6], 1'b1};
    watch(10, nc, ne, cy);
    chk("t4_short", nc + ne, 0);
    an_in = 8'hFF;
    watch(30, nc, ne, cy);
    chk("t4_short_off", nc + ne, 0);
    chk("t4_short_dig", digits_out, 32'hFFFF_FFF5);

    // T5: illegal glyph on digit 5, then blank
    an_in = 8'hDF; seg_in = 8'h55;
    watch(25, nc, ne, cy);
    chk("t5_nerr", ne, 1);
    chk("t5_ncap", nc, 0);
    chk("t5_cyc", cy, 18);
    chk("t5_idx", {29'h0, capt_idx}, 5);
    chk("t5_valid", {24'h0, digit_valid}, 32'hDF);
    chk("t5_dp", {24'h0, dp_out}, 32'hAA);
    chk("t5_digits", digits_out, 32'hFFFF_FFF5);
    seg_in = 8'hFF;
    watch(25, nc, ne, cy);
    chk("t5_blank_pulses", nc + ne, 0);
    chk("t5_blank_valid", {24'h0, digit_valid}, 32'hDF);
    chk("t5_blank_dp", {24'h0, dp_out}, 32'h8A);
    chk("t5_blank_digits", digits_out, 32'hFFFF_FFF5);

    // T6: anode faults leave everything alone
    an_in = 8'hF3; seg_in = 8'h0D;
    watch(30, nc, ne, cy);
    chk("t6_two_low", nc + ne, 0);
    an_in = 8'hFF; seg_in = 8'h00;
    watch(30, nc, ne, cy);
    chk("t6_none_low", nc + ne, 0);
    chk("t6_digits", digits_out, 32'hFFFF_FFF5);
    chk("t6_dp", {24'h0, dp_out}, 32'h8A);
    chk("t6_valid", {24'h0, digit_valid}, 32'hDF);
    chk("t6_idx", {29'h0, capt_idx}, 5);

    // T1: reset in the middle of a count (cnt=7)
    an_in = 8'hFB; seg_in = 8'h0D;
    watch(9, nc, ne, cy);
    chk("t1_pre", nc + ne, 0);
    reset_n = 1'b0; #1;
    chk("t1_digits", digits_out, 32'h0);
    chk("t1_dp", {24'h0, dp_out}, 32'h0);
    chk("t1_valid", {24'h0, digit_valid}, 32'h0);
    chk("t1_idx", {29'h0, capt_idx}, 0);
    repeat (3) @(posedge clk); #1;
    reset_n = 1'b1;
    watch(30, nc, ne, cy);
    chk("t1_ncap", nc, 1);
    chk("t1_cyc", cy, 20);
    chk("t1_after_digits", digits_out, 32'h0000_0300);
    chk("t1_after_valid", {24'h0, digit_valid}, 32'h04);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
